// File: rtl/vga_param_controller.sv
// VGA timing generator with registered colour/sync output stage.
// Counters drive the pixel request; colour and syncs follow one cycle later.
module vga_param_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 4,
  parameter int CNT_W    = 10
) (
  input  logic                 i_CLK,
  input  logic                 i_RESET,
  input  logic [3*COLOR_W-1:0] i_RGB,
  input  logic                 i_PATTERN,
  output logic                 o_REQ,
  output logic [CNT_W-1:0]     o_X,
  output logic [CNT_W-1:0]     o_Y,
  output logic                 o_HSYNC,
  output logic                 o_VSYNC,
  output logic [COLOR_W-1:0]   o_RED,
  output logic [COLOR_W-1:0]   o_GREEN,
  output logic [COLOR_W-1:0]   o_BLUE,
  output logic                 o_DE,
  output logic                 o_FRAME_START,
  output logic [7:0]           o_FRAME_CNT
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0]   h_cnt;
  logic [CNT_W-1:0]   v_cnt;
  logic               h_wrap;
  logic               v_wrap;
  logic               frame_wrap;
  logic               pat;
  logic               in_hs;
  logic               in_vs;
  logic               at_origin;
  logic [2:0]         bar;
  logic [COLOR_W-1:0] red_n;
  logic [COLOR_W-1:0] green_n;
  logic [COLOR_W-1:0] blue_n;

  assign h_wrap     = (h_cnt == H_LAST);
  assign v_wrap     = (v_cnt == V_LAST);
  assign frame_wrap = h_wrap && v_wrap;
  assign at_origin  = (h_cnt == '0) && (v_cnt == '0);

  assign o_X   = h_cnt;
  assign o_Y   = v_cnt;
  assign o_REQ = (h_cnt < H_ACT) && (v_cnt < V_ACT);

  assign in_hs = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign in_vs = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

  // Raster counters: h every cycle, v on each line wrap
  always_ff @(posedge i_CLK) begin
    if (!i_RESET) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= v_wrap ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  // Frame counter and pattern select, updated only at frame boundary
  always_ff @(posedge i_CLK) begin
    if (!i_RESET) begin
      o_FRAME_CNT <= 8'd0;
      pat         <= 1'b0;
    end else if (frame_wrap) begin
      o_FRAME_CNT <= o_FRAME_CNT + 8'd1;
      pat         <= i_PATTERN;
    end
  end

  // Colour-bar index: count how many bar boundaries X has passed
  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h_cnt >= CNT_W'(k * BAR_W)) begin
        bar = bar + 3'd1;
      end
    end
  end

  // Next colour: black outside active area, else bars or pixel input
  always_comb begin
    red_n   = '0;
    green_n = '0;
    blue_n  = '0;
    if (o_REQ) begin
      if (pat) begin
        red_n   = {COLOR_W{bar[2]}};
        green_n = {COLOR_W{bar[1]}};
        blue_n  = {COLOR_W{bar[0]}};
      end else begin
        red_n   = i_RGB[3*COLOR_W-1 -: COLOR_W];
        green_n = i_RGB[2*COLOR_W-1 -: COLOR_W];
        blue_n  = i_RGB[COLOR_W-1:0];
      end
    end
  end

  // Single output register stage for colour, syncs, DE and frame pulse
  always_ff @(posedge i_CLK) begin
    if (!i_RESET) begin
      o_HSYNC       <= ~HS_POL;
      o_VSYNC       <= ~VS_POL;
      o_RED         <= '0;
      o_GREEN       <= '0;
      o_BLUE        <= '0;
      o_DE          <= 1'b0;
      o_FRAME_START <= 1'b0;
    end else begin
      o_HSYNC       <= in_hs ? HS_POL : ~HS_POL;
      o_VSYNC       <= in_vs ? VS_POL : ~VS_POL;
      o_RED         <= red_n;
      o_GREEN       <= green_n;
      o_BLUE        <= blue_n;
      o_DE          <= o_REQ;
      o_FRAME_START <= at_origin;
    end
  end

endmodule

// File: tb/tb_vga_param_controller.sv
// Bench for vga_param_controller: linear-index raster model plus
// directed literal checks; a tiny second instance covers frame-count wrap.
module tb_vga_param_controller;

  localparam int HA = 640;
  localparam int HF = 16;
  localparam int HS = 96;
  localparam int HB = 48;
  localparam int VA = 24;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int FR2 = 12 * 5;
  localparam int RST_AT = 64300;
  localparam int LAST = 65400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        pat;
  logic [11:0] rgb;

  logic       req, hs, vs, de, fs;
  logic [9:0] x, y;
  logic [3:0] r, g, b;
  logic [7:0] fc;

  logic       req2, hs2, vs2, de2, fs2;
  logic [3:0] x2, y2;
  logic [3:0] r2, g2, b2;
  logic [7:0] fc2;

  vga_param_controller #(
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .i_CLK(clk), .i_RESET(rst_n), .i_RGB(rgb), .i_PATTERN(pat),
    .o_REQ(req), .o_X(x), .o_Y(y), .o_HSYNC(hs), .o_VSYNC(vs),
    .o_RED(r), .o_GREEN(g), .o_BLUE(b), .o_DE(de),
    .o_FRAME_START(fs), .o_FRAME_CNT(fc)
  );

  vga_param_controller #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(2),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CNT_W(4)
  ) dut2 (
    .i_CLK(clk), .i_RESET(rst_n), .i_RGB(rgb), .i_PATTERN(pat),
    .o_REQ(req2), .o_X(x2), .o_Y(y2), .o_HSYNC(hs2), .o_VSYNC(vs2),
    .o_RED(r2), .o_GREEN(g2), .o_BLUE(b2), .o_DE(de2),
    .o_FRAME_START(fs2), .o_FRAME_CNT(fc2)
  );

  int c = -1;
  int errors = 0;
  int checks = 0;
  bit mdl_ok = 1'b0;

  int t, f, t2, f2, mh, mv;
  bit pm;
  bit e_hs, e_vs, e_de, e_fs, e_fs2, e_de2;
  logic [11:0] e_rgb;

  int de_n = 0, hs_n = 0, vs_n = 0;
  int hs_first = -1, vs_first = -1;

  function automatic logic [11:0] bar_rgb(int h);
    logic [2:0] bi;
    bi = 3'(h / (HA / 8));
    return {bi[2] ? 4'hF : 4'h0, bi[1] ? 4'hF : 4'h0, bi[0] ? 4'hF : 4'h0};
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, c);
    end
  endtask

  // Reference model: raster position as a linear index within the frame
  always @(posedge clk) begin
    if (!rst_n) begin
      t = 0; f = 0; pm = 1'b0;
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0; e_rgb = '0;
      t2 = 0; f2 = 0; e_fs2 = 1'b0; e_de2 = 1'b0;
      mdl_ok = 1'b1;
    end else begin
      mh = t % HT;
      mv = t / HT;
      e_de = (mh < HA) && (mv < VA);
      e_hs = !((mh >= HA + HF) && (mh < HA + HF + HS));
      e_vs = !((mv >= VA + VF) && (mv < VA + VF + VS));
      e_fs = (t == 0);
      e_rgb = !e_de ? 12'h000 : (pm ? bar_rgb(mh) : rgb);
      t++;
      if (t == FR) begin
        t = 0;
        f = (f + 1) % 256;
        pm = pat;
      end
      e_de2 = ((t2 % 12) < 8) && ((t2 / 12) < 2);
      e_fs2 = (t2 == 0);
      t2++;
      if (t2 == FR2) begin
        t2 = 0;
        f2 = (f2 + 1) % 256;
      end
    end
  end

  // Compare process: model checks every cycle plus pinned literals
  always @(negedge clk) begin
    if (mdl_ok) begin
      chk("x", int'(x), t % HT);
      chk("y", int'(y), t / HT);
      chk("req", int'(req), int'(((t % HT) < HA) && ((t / HT) < VA)));
      chk("hsync", int'(hs), int'(e_hs));
      chk("vsync", int'(vs), int'(e_vs));
      chk("de", int'(de), int'(e_de));
      chk("fstart", int'(fs), int'(e_fs));
      chk("fcnt", int'(fc), f);
      chk("rgb", int'({r, g, b}), int'(e_rgb));
      chk("x2", int'(x2), t2 % 12);
      chk("y2", int'(y2), t2 / 12);
      chk("de2", int'(de2), int'(e_de2));
      chk("fstart2", int'(fs2), int'(e_fs2));
      chk("fcnt2", int'(fc2), f2);

      if (c >= 1 && c <= HT) begin
        if (de) de_n++;
        if (!hs) begin
          hs_n++;
          if (hs_first < 0) hs_first = c;
        end
      end
      if (c >= 1 && c <= FR && !vs) begin
        vs_n++;
        if (vs_first < 0) vs_first = c;
      end

      if (c == 0) begin
        chk("lit_rel_req", int'(req), 1);
        chk("lit_rel_x", int'(x), 0);
        chk("lit_rel_de", int'(de), 0);
      end
      if (c == 1) begin
        chk("lit_c1_de", int'(de), 1);
        chk("lit_c1_fs", int'(fs), 1);
        chk("lit_c1_rgb", int'({r, g, b}), 'hABC);
      end
      if (c == HT + 1) begin
        chk("lit_line0_de_cycles", de_n, 640);
        chk("lit_hs_low_cycles", hs_n, 96);
        chk("lit_hs_first", hs_first, 657);
      end
      if (c == 12001) chk("lit_f0_direct_rgb", int'({r, g, b}), 'hFFF);
      if (c == 12641) chk("lit_hblank_rgb", int'({r, g, b}), 0);
      if (c == 20001) chk("lit_vblank_rgb", int'({r, g, b}), 0);
      if (c == 15359) chk("lit_fcnt2_255", int'(fc2), 255);
      if (c == 15360) chk("lit_fcnt2_wrap", int'(fc2), 0);
      if (c == FR + 1) begin
        chk("lit_vs_low_cycles", vs_n, 1600);
        chk("lit_vs_first", vs_first, 20801);
        chk("lit_f1_fs", int'(fs), 1);
        chk("lit_f1_fcnt", int'(fc), 1);
        chk("lit_bar0", int'({r, g, b}), 'h000);
      end
      if (c == FR + 2) chk("lit_fs_width", int'(fs), 0);
      if (c == FR + 81) chk("lit_bar1", int'({r, g, b}), 'h00F);
      if (c == FR + 241) chk("lit_bar3", int'({r, g, b}), 'h0FF);
      if (c == FR + 561) chk("lit_bar7", int'({r, g, b}), 'hFFF);
      if (c == 2 * FR + 1) begin
        chk("lit_f2_fs", int'(fs), 1);
        chk("lit_f2_fcnt", int'(fc), 2);
      end
      if (c == RST_AT) begin
        chk("lit_pre_rst_x", int'(x), 300);
        chk("lit_pre_rst_y", int'(y), 20);
      end
      if (c == RST_AT + 1) begin
        chk("lit_rst_hs", int'(hs), 1);
        chk("lit_rst_vs", int'(vs), 1);
        chk("lit_rst_de", int'(de), 0);
        chk("lit_rst_fs", int'(fs), 0);
        chk("lit_rst_rgb", int'({r, g, b}), 0);
        chk("lit_rst_x", int'(x), 0);
        chk("lit_rst_fcnt", int'(fc), 0);
      end
      if (c == RST_AT + 3) begin
        chk("lit_after_rst_x", int'(x), 0);
        chk("lit_after_rst_y", int'(y), 0);
        chk("lit_after_rst_req", int'(req), 1);
        chk("lit_after_rst_fcnt", int'(fc), 0);
      end
      if (c == RST_AT + 4) begin
        chk("lit_after_rst_de", int'(de), 1);
        chk("lit_after_rst_fs", int'(fs), 1);
      end
    end
  end

  // Stimulus: inputs for cycle c are applied just after the edge opening it
  initial begin
    rst_n = 1'b0;
    pat   = 1'b0;
    rgb   = 12'hABC;
    repeat (3) @(posedge clk);
    #1;
    c = 0;
    while (c <= LAST) begin
      rst_n = !(c >= RST_AT && c < RST_AT + 3);
      pat   = (c >= 12000 && c < 30000);
      if (c < HT) rgb = 12'hABC;
      else if (c < 12000) rgb = 12'(c * 37);
      else if (c < FR) rgb = 12'hFFF;
      else rgb = 12'(c * 37);
      @(posedge clk);
      #1;
      c++;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
